// File: rtl/frame_ctrl_pkg.sv
// frame_ctrl_pkg: shared types and defaults for the frame sequencing controller.
//   ctrl_state_e           - FSM state encoding (IDLE..HOLD)
//   FRAME_CTRL_DEFAULT_DIV - default fastClk cycles per stage tick
package frame_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    CAPTURE  = 3'd2,
    DECODE   = 3'd3,
    MULTIPLY = 3'd4,
    HOLD     = 3'd5
  } ctrl_state_e;

  localparam int FRAME_CTRL_DEFAULT_DIV = 2;

endpackage

// File: rtl/frame_ctrl_if.sv
// frame_ctrl_if: control/handshake bundle between frame_ctrl and its environment.
//   control, bitValid, outReady           - requests into the controller
//   shiftEn, captureEn, decodeEn,
//   multiplyEn                            - one-cycle datapath load strobes
//   outValid, busy, overrun               - status / result handshake
// Modports: slave = controller view, master = environment view.
interface frame_ctrl_if;

  logic control;
  logic bitValid;
  logic outReady;
  logic shiftEn;
  logic captureEn;
  logic decodeEn;
  logic multiplyEn;
  logic outValid;
  logic busy;
  logic overrun;

  modport slave (
    input  control, bitValid, outReady,
    output shiftEn, captureEn, decodeEn, multiplyEn, outValid, busy, overrun
  );

  modport master (
    output control, bitValid, outReady,
    input  shiftEn, captureEn, decodeEn, multiplyEn, outValid, busy, overrun
  );

endinterface

// File: rtl/frame_ctrl_tick_gen.sv
// tick_gen: free-running divided-rate tick for the slow datapath stages.
//   fastClk - clock
//   reset   - synchronous active-high reset (count to 0)
//   tick    - high while the count equals DIV_RATIO-1
// The count is never cleared by the FSM, so tick phase is global.
module tick_gen
  import frame_ctrl_pkg::*;
#(
  parameter int DIV_RATIO = FRAME_CTRL_DEFAULT_DIV
) (
  input  logic fastClk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_RATIO - 1);

  logic [CW-1:0] count;

  always_ff @(posedge fastClk) begin
    if (reset)              count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/frame_ctrl.sv
// frame_ctrl: sequencing controller for the serial-to-parallel datapath.
// Counts DATA_WIDTH serial bits, fires a one-cycle capture enable, then steps
// decode and multiply on divided-rate ticks and holds the result with a
// valid/ready handshake.
//   fastClk - sole clock, rising edge
//   reset   - synchronous active-high reset
//   bus     - frame_ctrl_if.slave (control/bitValid/outReady in; strobes and
//             status out)
// Optional build macro: FRAME_CTRL_OVERRUN_EN adds the sticky overrun flag for
// bits arriving outside IDLE/SHIFT; without it overrun is tied to 0.
// DATA_WIDTH and DIV_RATIO are both expected to be >= 2.
module frame_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int DIV_RATIO  = FRAME_CTRL_DEFAULT_DIV
) (
  input  logic         fastClk,
  input  logic         reset,
  frame_ctrl_if.slave  bus
);

  localparam int               CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DATA_WIDTH);

  ctrl_state_e      state, state_next;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic             tick;
  logic             shift_en, capture_en, decode_en, multiply_en, out_valid;

  tick_gen #(.DIV_RATIO(DIV_RATIO)) u_tick_gen (
    .fastClk (fastClk),
    .reset   (reset),
    .tick    (tick)
  );

  always_ff @(posedge fastClk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_en     = 1'b0;
    capture_en   = 1'b0;
    decode_en    = 1'b0;
    multiply_en  = 1'b0;
    out_valid    = 1'b0;
    case (state)
      IDLE: begin
        shift_en = bus.control & bus.bitValid;
        if (shift_en) begin
          bit_cnt_next = CNT_W'(1);
          state_next   = (FULL == CNT_W'(1)) ? CAPTURE : SHIFT;
        end
      end
      SHIFT: begin
        // control is not looked at here: a started frame always completes
        shift_en = bus.bitValid;
        if (shift_en) begin
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt_next == FULL) state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        capture_en   = 1'b1;
        bit_cnt_next = '0;
        state_next   = DECODE;
      end
      DECODE: begin
        if (tick) begin
          decode_en  = 1'b1;
          state_next = MULTIPLY;
        end
      end
      MULTIPLY: begin
        if (tick) begin
          multiply_en = 1'b1;
          state_next  = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.outReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.shiftEn    = shift_en;
  assign bus.captureEn  = capture_en;
  assign bus.decodeEn   = decode_en;
  assign bus.multiplyEn = multiply_en;
  assign bus.outValid   = out_valid;
  assign bus.busy       = (state != IDLE);

`ifdef FRAME_CTRL_OVERRUN_EN
  // A bit seen after the frame is full is lost; remember that until reset.
  logic dropped;
  logic overrun_q;

  assign dropped = bus.bitValid &
                   ((state == CAPTURE) || (state == DECODE) ||
                    (state == MULTIPLY) || (state == HOLD));

  always_ff @(posedge fastClk) begin
    if (reset)        overrun_q <= 1'b0;
    else if (dropped) overrun_q <= 1'b1;
  end

  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_frame_ctrl.sv
// tb_frame_ctrl: table-driven bench for frame_ctrl (DATA_WIDTH=4, DIV_RATIO=2).
// Each table row holds {reset, control, bitValid, outReady} and the expected
// {shiftEn, captureEn, decodeEn, multiplyEn, outValid, busy, overrun} for that
// cycle. Rows are driven just after a rising edge; the expected word is queued
// and compared on the following falling edge. Hand-written sequences cover the
// dropped-bit / overrun behaviour and reset clearing.
module tb_frame_ctrl;

  typedef struct packed {
    logic [3:0] in;
    logic [6:0] exp;
  } vec_t;

`ifdef FRAME_CTRL_OVERRUN_EN
  localparam logic OV_EXP = 1'b1;
`else
  localparam logic OV_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_ctrl_if bus ();

  frame_ctrl #(.DATA_WIDTH(4), .DIV_RATIO(2)) dut (
    .fastClk (clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  vec_t       vecs[$];
  logic [6:0] sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         vidx  = 0;

  function automatic logic [6:0] outs();
    return {bus.shiftEn, bus.captureEn, bus.decodeEn, bus.multiplyEn,
            bus.outValid, bus.busy, bus.overrun};
  endfunction

  function automatic void add(input logic [3:0] i, input logic [6:0] e, input int n = 1);
    vec_t v;
    v.in  = i;
    v.exp = e;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] in);
    @(posedge clk);
    #1;
    reset          = in[3];
    bus.control    = in[2];
    bus.bitValid   = in[1];
    bus.outReady   = in[0];
  endtask

  task automatic step(input logic [3:0] in);
    drive(in);
    @(negedge clk);
  endtask

  // Keeps outReady high; returns once outValid is seen or the budget runs out.
  task automatic wait_out(input int max, input string name);
    int k;
    k = 0;
    while (bus.outValid !== 1'b1 && k < max) begin
      step(4'b0001);
      k++;
    end
    check(name, {6'b0, bus.outValid}, 7'd1);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      logic [6:0] e;
      e = sb.pop_front();
      check($sformatf("vec%0d", vidx), outs(), e);
      vidx++;
    end
  end

  initial begin
    bus.control  = 1'b0;
    bus.bitValid = 1'b0;
    bus.outReady = 1'b0;

    // Continuous frame: bits at cycles 3-6, ticks on odd cycles.
    add(4'b0100, 7'b0000000);
    add(4'b0101, 7'b0000000, 2);
    add(4'b0111, 7'b1000000);
    add(4'b0111, 7'b1000010, 3);
    add(4'b0101, 7'b0100010);
    add(4'b0101, 7'b0000010);
    add(4'b0101, 7'b0010010);
    add(4'b0101, 7'b0000010);
    add(4'b0101, 7'b0001010);
    add(4'b0101, 7'b0000110);
    add(4'b0001, 7'b0000000);
    // Gapped bits 1,0,0,1,1,0,1 with control dropped mid-frame.
    add(4'b0110, 7'b1000000);
    add(4'b0000, 7'b0000010, 2);
    add(4'b0010, 7'b1000010, 2);
    add(4'b0000, 7'b0000010);
    add(4'b0010, 7'b1000010);
    add(4'b0000, 7'b0100010);
    add(4'b0000, 7'b0000010);
    add(4'b0000, 7'b0010010);
    add(4'b0001, 7'b0000010);          // early outReady in MULTIPLY
    add(4'b0000, 7'b0001010);
    // Backpressure: 10 cycles held, then transfer.
    add(4'b0000, 7'b0000110, 10);
    add(4'b0001, 7'b0000110);
    // Control gating: bits with control=0 in IDLE are ignored.
    add(4'b0010, 7'b0000000, 2);
    // Reset after two accepted bits, then a clean frame.
    add(4'b0110, 7'b1000000);
    add(4'b0110, 7'b1000010);
    add(4'b1000, 7'b0000010);
    add(4'b0000, 7'b0000000);
    add(4'b0110, 7'b1000000);
    add(4'b0110, 7'b1000010, 3);
    add(4'b0000, 7'b0100010);
    add(4'b0000, 7'b0000010);
    add(4'b0000, 7'b0010010);
    add(4'b0000, 7'b0000010);
    add(4'b0000, 7'b0001010);
    add(4'b0001, 7'b0000110);
    add(4'b0000, 7'b0000000);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].in);
      sb.push_back(vecs[i].exp);
    end
    @(negedge clk);

    // Bit arriving in DECODE is dropped and (when built) flags overrun.
    repeat (4) step(4'b0110);
    check("ov_bit4", {6'b0, bus.shiftEn}, 7'd1);
    step(4'b0000);
    check("ov_capture", {6'b0, bus.captureEn}, 7'd1);
    step(4'b0010);
    check("ov_drop", {5'b0, bus.shiftEn, bus.busy}, 7'b0000001);
    step(4'b0000);
    check("ov_flag", {6'b0, bus.overrun}, {6'b0, OV_EXP});
    wait_out(20, "ov_done1");
    step(4'b0000);
    check("ov_idle", {5'b0, bus.busy, bus.overrun}, {5'b0, 1'b0, OV_EXP});
    repeat (4) step(4'b0110);
    wait_out(20, "ov_done2");
    step(4'b0000);
    check("ov_sticky", {6'b0, bus.overrun}, {6'b0, OV_EXP});
    step(4'b1000);
    step(4'b0000);
    check("reset_clear", outs(), 7'b0000000);

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_ctrl.md
# frame_ctrl

Sequencing controller for the serial-to-parallel datapath. It counts serial bits into the shift register, fires the one-cycle capture enable into the synchronizer register, and then steps the decode and multiply stages on divided-rate ticks. It presents the result with a valid/ready handshake. It runs entirely on the fast clock and replaces the ad-hoc `clkOut & slowClk` enable with explicit, cycle-exact stage enables.

## Interface
- `DATA_WIDTH`, 4: bits per frame; must be ≥ 2.
- `DIV_RATIO`, 2: fastClk cycles per stage tick (slow-rate emulation); must be ≥ 2.
- `fastClk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `control` in 1: run enable, sampled only in IDLE.
- `bitValid` in 1: a serial bit is present on the datapath this cycle.
- `outReady` in 1: downstream accepts the result.
- `shiftEn` out 1: shift register load strobe (combinational from state and `bitValid`).
- `captureEn` out 1: synchronizer register load strobe.
- `decodeEn` out 1: decode register load strobe.
- `multiplyEn` out 1: multiply register load strobe.
- `outValid` out 1: result held valid.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: sticky dropped-bit flag (see Configuration).

## Operation
- Free-running tick counter runs 0..`DIV_RATIO`-1. `tick` is high when the count equals `DIV_RATIO`-1.
- Bit counter is $clog2(DATA_WIDTH+1) bits wide and counts accepted bits.
- States and transitions:
  - IDLE: `shiftEn = control & bitValid`. If that is 1, the counter becomes 1 and the FSM goes to SHIFT (or to CAPTURE if `DATA_WIDTH` accepted bits are already reached; this cannot happen for `DATA_WIDTH` ≥ 2).
  - SHIFT: `shiftEn = bitValid`. Each accepted bit increments the counter. The accept that makes the count equal `DATA_WIDTH` moves the FSM to CAPTURE. Cycles with `bitValid` = 0 stall with no timeout.
  - CAPTURE: `captureEn` = 1 for exactly one cycle, then DECODE. The bit counter clears.
  - DECODE: waits for `tick`. In the tick cycle `decodeEn` = 1, then MULTIPLY.
  - MULTIPLY: waits for the next `tick`. In that cycle `multiplyEn` = 1, then HOLD.
  - HOLD: `outValid` = 1. On `outValid & outReady` the FSM goes to IDLE.
- All strobes are mutually exclusive and each is high for one cycle only.
- `bitValid` outside IDLE/SHIFT: the bit is dropped and `shiftEn` stays 0. A bit in IDLE with `control` = 0 is ignored and is not an overrun.
- `control` deasserting mid-frame has no effect; the frame completes.

## Timing
- Reset values: state IDLE, both counters 0, every output 0.
- Reset asserted in any state takes effect at the next edge and aborts the frame with no completion strobe.
- Last bit accepted at cycle N:
  - `captureEn` at N+1.
  - `decodeEn` at the first tick cycle ≥ N+2.
  - `multiplyEn` exactly `DIV_RATIO` cycles after `decodeEn`.
  - `outValid` rises one cycle after `multiplyEn`.
- Handshake: `outValid` stays high and stable until a cycle where `outReady` = 1. IDLE follows on the next cycle. `outReady` arriving early has no effect.
- Minimum frame-to-frame gap: the first bit of the next frame is accepted no earlier than the cycle after the transfer.
- Tick counter is never reset by the FSM, so tick phase is global.

## Configuration
- `FRAME_CTRL_OVERRUN_EN` defined:
  - `overrun` sets on any `bitValid` = 1 in CAPTURE, DECODE, MULTIPLY or HOLD.
  - It stays set until `reset`. The flag is registered and visible one cycle after the dropped bit.
- Undefined: `overrun` is tied to 0 and no flag register is built. Dropped bits are still dropped.

## Structure
- `frame_ctrl_pkg` holds:
  - `ctrl_state_e` (IDLE, SHIFT, CAPTURE, DECODE, MULTIPLY, HOLD) as an enum logic [2:0].
  - `FRAME_CTRL_DEFAULT_DIV` = 2.
- Sub-module `tick_gen` (parameter `DIV_RATIO`; ports `fastClk`, `reset`, `tick`) holds the free-running counter.
- FSM and bit counter live in `frame_ctrl`.

## Test plan
All scenarios use `DATA_WIDTH`=4 and `DIV_RATIO`=2.
- **Continuous frame:** reset release, `control`=1, `bitValid`=1 for 4 cycles from cycle 3, `outReady`=1 → `shiftEn` cycles 3-6, `captureEn` cycle 7, `decodeEn` cycle 9, `multiplyEn` cycle 11, `outValid` cycle 12, `busy` 0 at cycle 13.
- **Gapped bits:** `bitValid` pattern 1,0,0,1,1,0,1 → exactly 4 `shiftEn` pulses; `captureEn` on the cycle after the 4th pulse.
- **Backpressure:** `outReady`=0 for 10 cycles after `outValid` → `outValid` held 10+ cycles with no further strobes; transfer on the first `outReady`=1 cycle, then IDLE.
- **Overrun (macro on):** `bitValid`=1 during DECODE → no `shiftEn`, `overrun`=1 next cycle and held through the next frame until `reset`. With the macro off, `overrun` stays 0.
- **Reset mid-frame:** `reset` asserted after 2 accepted bits → next cycle IDLE with all outputs 0. A new 4-bit frame then completes with normal timing.
- **Control gating:** `control`=0 with `bitValid`=1 in IDLE → no `shiftEn`, `busy`=0, `overrun`=0.
